// File: rtl/trig_event_latch.sv
// Saturating per-channel event counters with a host-triggered copy into a readable shadow bank.
// Build option: define TRIG_EVENT_BOTH_EDGES_EN to count both edges of ev_in.
module trig_event_latch #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         ev_in,
  input  logic                    snap_trig,
  input  logic                    clr_trig,
  input  logic [$clog2(N_CH)-1:0] rd_sel,
  output logic [CNT_W-1:0]        rd_count,
  output logic [N_CH-1:0]         pend,
  output logic [N_CH-1:0]         ovf,
  output logic                    busy,
  output logic                    snap_done
);

  localparam int unsigned SelW = $clog2(N_CH);
  localparam logic [SelW-1:0] LastIdx = SelW'(N_CH - 1);
`ifdef TRIG_EVENT_BOTH_EDGES_EN
  localparam logic [N_CH-1:0] EvRst = '0;
`else
  // All-ones so a line already high at reset release is not counted.
  localparam logic [N_CH-1:0] EvRst = '1;
`endif

  typedef enum logic [1:0] {StIdle, StCopy, StDone} state_e;

  state_e                     state_q, state_d;
  logic [SelW-1:0]            idx_q, idx_d;
  logic [N_CH-1:0]            ev_q, rise;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] sh_cnt_q, sh_cnt_d;
  logic [N_CH-1:0]            live_ovf_q, live_ovf_d;
  logic [N_CH-1:0]            sh_ovf_q, sh_ovf_d;

  always_comb begin
`ifdef TRIG_EVENT_BOTH_EDGES_EN
    rise = ev_in ^ ev_q;
`else
    rise = ev_in & ~ev_q;
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    live_ovf_d = live_ovf_q;
    sh_cnt_d   = sh_cnt_q;
    sh_ovf_d   = sh_ovf_q;

    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rise[i]) begin
        if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          live_ovf_d[i] = 1'b1;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        // A simultaneous clear is dropped: the snapshot rewrites the whole shadow bank.
        if (snap_trig) begin
          state_d = StCopy;
          idx_d   = '0;
        end else if (clr_trig) begin
          sh_cnt_d = '0;
          sh_ovf_d = '0;
        end
      end
      StCopy: begin
        sh_cnt_d[idx_q]   = cnt_q[idx_q];
        sh_ovf_d[idx_q]   = live_ovf_q[idx_q];
        // An event landing on its own copy cycle opens the next live period.
        cnt_d[idx_q]      = rise[idx_q] ? CNT_W'(1) : '0;
        live_ovf_d[idx_q] = 1'b0;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + SelW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ev_q       <= EvRst;
      cnt_q      <= '0;
      live_ovf_q <= '0;
      sh_cnt_q   <= '0;
      sh_ovf_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ev_q       <= ev_in;
      cnt_q      <= cnt_d;
      live_ovf_q <= live_ovf_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_ovf_q   <= sh_ovf_d;
    end
  end

  always_comb begin
    rd_count = '0;
    if (32'(rd_sel) < N_CH) begin
      rd_count = sh_cnt_q[rd_sel];
    end
    pend = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pend[i] = (sh_cnt_q[i] != '0) | sh_ovf_q[i];
    end
  end

  assign ovf       = sh_ovf_q;
  assign busy      = (state_q != StIdle);
  assign snap_done = (state_q == StDone);

endmodule

// File: tb/tb_trig_event_latch.sv
// Bench for trig_event_latch: directed scenarios plus random traffic, checked against an
// event-count reference model.
module tb_trig_event_latch;

  localparam int unsigned NCh  = 8;
  localparam int unsigned CntW = 8;
  localparam int          CntMax = 255;
`ifdef TRIG_EVENT_BOTH_EDGES_EN
  localparam int EdgeMult = 2;
`else
  localparam int EdgeMult = 1;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NCh-1:0]  ev_in;
  logic            snap_trig;
  logic            clr_trig;
  logic [2:0]      rd_sel;
  logic [CntW-1:0] rd_count;
  logic [NCh-1:0]  pend;
  logic [NCh-1:0]  ovf;
  logic            busy;
  logic            snap_done;

  trig_event_latch #(.N_CH(NCh), .CNT_W(CntW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ev_in    (ev_in),
    .snap_trig(snap_trig),
    .clr_trig (clr_trig),
    .rd_sel   (rd_sel),
    .rd_count (rd_count),
    .pend     (pend),
    .ovf      (ovf),
    .busy     (busy),
    .snap_done(snap_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: true event totals since each channel's last copy, shadow contents,
  // and the number of edges elapsed since the snapshot trigger (0 = idle).
  int             m_ev  [NCh];
  int             m_sh  [NCh];
  bit             m_sov [NCh];
  int             m_phase;
  logic [NCh-1:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCh; i++) begin
      m_ev[i]  = 0;
      m_sh[i]  = 0;
      m_sov[i] = 1'b0;
    end
    m_phase = 0;
`ifdef TRIG_EVENT_BOTH_EDGES_EN
    m_prev = '0;
`else
    m_prev = '1;
`endif
  endfunction

  function automatic void model_edge(input logic [NCh-1:0] ev, input logic snap,
                                     input logic clr);
    logic [NCh-1:0] r;
`ifdef TRIG_EVENT_BOTH_EDGES_EN
    r = ev ^ m_prev;
`else
    r = ev & ~m_prev;
`endif
    for (int i = 0; i < NCh; i++) begin
      if (m_phase >= 1 && m_phase <= NCh && i == m_phase - 1) begin
        m_sh[i]  = (m_ev[i] > CntMax) ? CntMax : m_ev[i];
        m_sov[i] = (m_ev[i] > CntMax);
        m_ev[i]  = r[i] ? 1 : 0;
      end else begin
        m_ev[i] += r[i] ? 1 : 0;
      end
    end
    if (m_phase == 0) begin
      if (snap) begin
        m_phase = 1;
      end else if (clr) begin
        for (int i = 0; i < NCh; i++) begin
          m_sh[i]  = 0;
          m_sov[i] = 1'b0;
        end
      end
    end else if (m_phase == NCh + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
    m_prev = ev;
  endfunction

  task automatic check_model(input logic [2:0] sel);
    logic [NCh-1:0] e_pend;
    logic [NCh-1:0] e_ovf;
    for (int i = 0; i < NCh; i++) begin
      e_pend[i] = (m_sh[i] != 0) || m_sov[i];
      e_ovf[i]  = m_sov[i];
    end
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
    chk("snap_done", snap_done, (m_phase == NCh + 1) ? 1 : 0);
    chk("pend", pend, e_pend);
    chk("ovf", ovf, e_ovf);
    chk("rd_count", rd_count, m_sh[sel]);
  endtask

  task automatic step(input logic [NCh-1:0] ev, input logic snap, input logic clr,
                      input logic [2:0] sel);
    ev_in     = ev;
    snap_trig = snap;
    clr_trig  = clr;
    rd_sel    = sel;
    @(posedge clk);
    model_edge(ev, snap, clr);
    #1;
    check_model(sel);
    snap_trig = 1'b0;
    clr_trig  = 1'b0;
  endtask

  task automatic pulses(input int ch, input int n);
    logic [NCh-1:0] b;
    b = '0;
    b[ch] = 1'b1;
    for (int k = 0; k < n; k++) begin
      step(b, 1'b0, 1'b0, 3'(ch));
      step('0, 1'b0, 1'b0, 3'(ch));
    end
  endtask

  // Trigger a snapshot, wait (bounded) for snap_done, then return to idle.
  task automatic snapshot_and_wait(input string tag);
    int lat;
    step('0, 1'b1, 1'b0, 3'd0);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      step('0, 1'b0, 1'b0, 3'd0);
      lat++;
      if (snap_done === 1'b1) break;
    end
    chk(tag, lat, NCh);
    step('0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic do_reset(input logic [NCh-1:0] ev);
    ev_in     = ev;
    snap_trig = 1'b0;
    clr_trig  = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", snap_done, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rd", rd_count, 0);
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_no_done", snap_done, 0);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    ev_in     = '0;
    snap_trig = 1'b0;
    clr_trig  = 1'b0;
    rd_sel    = '0;
    reset_n   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_pend", pend, 0);
    chk("init_rd", rd_count, 0);
    reset_n = 1'b1;
    step('0, 1'b0, 1'b0, 3'd0);

    // Basic count
    pulses(2, 5);
    pulses(7, 1);
    snapshot_and_wait("basic_latency");
    step('0, 1'b0, 1'b0, 3'd2);
    chk("basic_pend", pend, 8'h84);
    chk("basic_rd2", rd_count, 5 * EdgeMult);
    chk("basic_ovf", ovf, 0);
    step('0, 1'b0, 1'b0, 3'd7);
    chk("basic_rd7", rd_count, EdgeMult);

    // Saturation, then an empty snapshot
    pulses(0, 300);
    snapshot_and_wait("sat_latency");
    step('0, 1'b0, 1'b0, 3'd0);
    chk("sat_rd0", rd_count, 255);
    chk("sat_ovf0", ovf[0], 1);
    chk("sat_pend0", pend[0], 1);
    snapshot_and_wait("sat2_latency");
    step('0, 1'b0, 1'b0, 3'd0);
    chk("sat2_rd0", rd_count, 0);
    chk("sat2_ovf", ovf, 0);

    // Event on channel 3 in its own copy cycle (edge 4 after trigger)
    step('0, 1'b1, 1'b0, 3'd3);
    repeat (3) step('0, 1'b0, 1'b0, 3'd3);
    repeat (7) step(8'h08, 1'b0, 1'b0, 3'd3);
    chk("coin_idle", busy, 0);
    chk("coin_now", rd_count, 0);
    step('0, 1'b0, 1'b0, 3'd3);
    snapshot_and_wait("coin_latency");
    step('0, 1'b0, 1'b0, 3'd3);
    chk("coin_next", rd_count, EdgeMult);

    // Re-trigger during COPY yields a single snap_done
    step('0, 1'b1, 1'b0, 3'd0);
    step('0, 1'b0, 1'b0, 3'd0);
    step('0, 1'b0, 1'b0, 3'd0);
    dones = 0;
    step('0, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 20; k++) begin
      step('0, 1'b0, 1'b0, 3'd0);
      if (snap_done === 1'b1) dones++;
    end
    chk("retrig_dones", dones, 1);
    chk("retrig_idle", busy, 0);

    // Clear during COPY is ignored
    pulses(5, 2);
    step('0, 1'b1, 1'b0, 3'd5);
    step('0, 1'b0, 1'b1, 3'd5);
    step('0, 1'b0, 1'b1, 3'd5);
    repeat (10) step('0, 1'b0, 1'b0, 3'd5);
    chk("clrbusy_rd5", rd_count, 2 * EdgeMult);

    // Snapshot and clear together in idle: snapshot wins
    pulses(6, 1);
    step('0, 1'b1, 1'b1, 3'd6);
    chk("both_busy", busy, 1);
    repeat (10) step('0, 1'b0, 1'b0, 3'd6);
    chk("both_rd6", rd_count, EdgeMult);

    // Clear in idle leaves live counts intact
    pulses(4, 3);
    snapshot_and_wait("clr_latency");
    pulses(4, 2);
    step('0, 1'b0, 1'b1, 3'd4);
    chk("clr_pend", pend, 0);
    chk("clr_rd4", rd_count, 0);
    snapshot_and_wait("clr2_latency");
    step('0, 1'b0, 1'b0, 3'd4);
    chk("clr_live_rd4", rd_count, 2 * EdgeMult);

    // Reset in the middle of COPY
    pulses(1, 1);
    step('0, 1'b1, 1'b0, 3'd4);
    repeat (3) step('0, 1'b0, 1'b0, 3'd4);
    do_reset('0);
    repeat (12) step('0, 1'b0, 1'b0, 3'd4);

    // Lines held high through reset release
    do_reset('1);
    repeat (3) step('1, 1'b0, 1'b0, 3'd0);
    step('1, 1'b1, 1'b0, 3'd0);
    repeat (10) step('1, 1'b0, 1'b0, 3'd0);
`ifndef TRIG_EVENT_BOTH_EDGES_EN
    chk("held_pend", pend, 0);
`endif
    step('0, 1'b0, 1'b0, 3'd0);

`ifdef TRIG_EVENT_BOTH_EDGES_EN
    do_reset('0);
    pulses(1, 3);
    snapshot_and_wait("both_edges_latency");
    step('0, 1'b0, 1'b0, 3'd1);
    chk("both_edges_rd1", rd_count, 6);
`endif

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      logic [NCh-1:0] ev;
      ev = (k % 100 < 50) ? NCh'($urandom) : (ev_in ^ NCh'(1 << $urandom_range(0, NCh - 1)));
      step(ev, ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
           3'($urandom_range(0, NCh - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
